// File: rtl/fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pc_ctrl
// Description : Fetch-stage PC register and single-outstanding instruction
//               bus requester with a registered output slot for decode.
//               Responses belonging to a redirected-away fetch are dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pc_ctrl #(
  parameter logic [31:0] RESET_PC = 32'hbfc00000
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [31:0] pc_selected,
  input  logic        redirect,
  input  logic        stall,
  output logic [31:0] pc_succ,
  output logic        ireq,
  output logic [31:0] iaddr,
  input  logic        iaddr_ok,
  input  logic        idata_ok,
  input  logic [31:0] idata,
  output logic        f_valid,
  output logic [31:0] f_pc,
  output logic [31:0] f_instr,
  output logic        f_adel
);

  typedef enum logic [1:0] {
    ST_REQ  = 2'd0,
    ST_WAIT = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] req_pc_q, req_pc_d;
  logic        discard_q, discard_d;
  logic        f_valid_q, f_valid_d;
  logic [31:0] f_pc_q, f_pc_d;
  logic [31:0] f_instr_q, f_instr_d;
  logic        f_adel_q, f_adel_d;

  logic        pc_aligned;

  assign pc_aligned = (pc_q[1:0] == 2'b00);
  assign pc_succ    = pc_q + 32'd4;
  assign iaddr      = pc_q;
  assign f_valid    = f_valid_q;
  assign f_pc       = f_pc_q;
  assign f_instr    = f_instr_q;
  assign f_adel     = f_adel_q;

  // Request is suppressed on a redirect so a stale address is never issued.
  assign ireq = (state_q == ST_REQ) && pc_aligned && !redirect;

  // Next-state logic: redirect overrides every other transition.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    req_pc_d  = req_pc_q;
    discard_d = discard_q;
    f_valid_d = f_valid_q;
    f_pc_d    = f_pc_q;
    f_instr_d = f_instr_q;
    f_adel_d  = f_adel_q;

    if (redirect) begin
      pc_d      = pc_selected;
      f_valid_d = 1'b0;
      f_adel_d  = 1'b0;
      case (state_q)
        ST_HOLD: state_d = ST_REQ;
        ST_WAIT: begin
          if (idata_ok) begin
            // The in-flight response arrives now; drop it and refetch.
            discard_d = 1'b0;
            state_d   = ST_REQ;
          end else begin
            // Response still owed by the bus; remember to swallow it.
            discard_d = 1'b1;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end else begin
      case (state_q)
        ST_REQ: begin
          if (!pc_aligned) begin
            // Misaligned PC: never touch the bus, hand decode an AdEL slot.
            f_valid_d = 1'b1;
            f_adel_d  = 1'b1;
            f_instr_d = 32'd0;
            f_pc_d    = pc_q;
            state_d   = ST_HOLD;
          end else if (iaddr_ok) begin
            req_pc_d = pc_q;
            state_d  = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (idata_ok) begin
            if (discard_q) begin
              discard_d = 1'b0;
              state_d   = ST_REQ;
            end else begin
              f_valid_d = 1'b1;
              f_pc_d    = req_pc_q;
              f_instr_d = idata;
              f_adel_d  = 1'b0;
              state_d   = ST_HOLD;
            end
          end
        end
        ST_HOLD: begin
          if (!stall) begin
            f_valid_d = 1'b0;
            pc_d      = pc_selected;
            state_d   = ST_REQ;
          end
        end
        default: state_d = ST_REQ;
      endcase
    end
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_REQ;
      pc_q      <= RESET_PC;
      req_pc_q  <= 32'd0;
      discard_q <= 1'b0;
      f_valid_q <= 1'b0;
      f_pc_q    <= 32'd0;
      f_instr_q <= 32'd0;
      f_adel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      req_pc_q  <= req_pc_d;
      discard_q <= discard_d;
      f_valid_q <= f_valid_d;
      f_pc_q    <= f_pc_d;
      f_instr_q <= f_instr_d;
      f_adel_q  <= f_adel_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_pc_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pc_ctrl
// Description : Directed table-driven bench for fetch_pc_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pc_ctrl;

  logic        clk;
  logic        resetn;
  logic [31:0] pc_selected;
  logic        redirect;
  logic        stall;
  logic [31:0] pc_succ;
  logic        ireq;
  logic [31:0] iaddr;
  logic        iaddr_ok;
  logic        idata_ok;
  logic [31:0] idata;
  logic        f_valid;
  logic [31:0] f_pc;
  logic [31:0] f_instr;
  logic        f_adel;

  int errors = 0;
  int checks = 0;

  fetch_pc_ctrl #(.RESET_PC(32'hbfc00000)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .pc_selected(pc_selected),
    .redirect   (redirect),
    .stall      (stall),
    .pc_succ    (pc_succ),
    .ireq       (ireq),
    .iaddr      (iaddr),
    .iaddr_ok   (iaddr_ok),
    .idata_ok   (idata_ok),
    .idata      (idata),
    .f_valid    (f_valid),
    .f_pc       (f_pc),
    .f_instr    (f_instr),
    .f_adel     (f_adel)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One row = inputs for a cycle plus outputs expected during that cycle.
  typedef struct {
    logic        redirect;
    logic        stall;
    logic [31:0] pc_sel;
    logic        aok;
    logic        dok;
    logic [31:0] idata;
    logic        e_ireq;
    logic [31:0] e_iaddr;
    logic        e_fv;
    logic [31:0] e_fpc;
    logic [31:0] e_fi;
    logic        e_adel;
  } vec_t;

  localparam int NV = 30;
  vec_t vecs[NV];
  int   nv = 0;

  task automatic add(input logic rd, input logic st, input logic [31:0] ps,
                     input logic aok, input logic dok, input logic [31:0] dat,
                     input logic e_ireq, input logic [31:0] e_iaddr,
                     input logic e_fv, input logic [31:0] e_fpc,
                     input logic [31:0] e_fi, input logic e_adel);
    vecs[nv].redirect = rd;
    vecs[nv].stall    = st;
    vecs[nv].pc_sel   = ps;
    vecs[nv].aok      = aok;
    vecs[nv].dok      = dok;
    vecs[nv].idata    = dat;
    vecs[nv].e_ireq   = e_ireq;
    vecs[nv].e_iaddr  = e_iaddr;
    vecs[nv].e_fv     = e_fv;
    vecs[nv].e_fpc    = e_fpc;
    vecs[nv].e_fi     = e_fi;
    vecs[nv].e_adel   = e_adel;
    nv++;
  endtask

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic check_all(input int idx, input logic e_ireq,
                           input logic [31:0] e_iaddr, input logic e_fv,
                           input logic [31:0] e_fpc, input logic [31:0] e_fi,
                           input logic e_adel);
    chk("ireq",    idx, {31'd0, ireq},    {31'd0, e_ireq});
    chk("iaddr",   idx, iaddr,            e_iaddr);
    chk("pc_succ", idx, pc_succ,          e_iaddr + 32'd4);
    chk("f_valid", idx, {31'd0, f_valid}, {31'd0, e_fv});
    chk("f_pc",    idx, f_pc,             e_fpc);
    chk("f_instr", idx, f_instr,          e_fi);
    chk("f_adel",  idx, {31'd0, f_adel},  {31'd0, e_adel});
  endtask

  task automatic drive(input logic rd, input logic st, input logic [31:0] ps,
                       input logic aok, input logic dok, input logic [31:0] dat);
    redirect    = rd;
    stall       = st;
    pc_selected = ps;
    iaddr_ok    = aok;
    idata_ok    = dok;
    idata       = dat;
  endtask

  initial begin
    //   rd st pc_sel        aok dok idata          ireq iaddr         fv f_pc          f_instr       adel
    // Sequential fetch of two instructions, 3-cycle period
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00000, 0, 32'h0,        32'h0,        0); // 0 REQ
    add(0, 0, 32'h0,        0, 1, 32'h24010001, 0, 32'hbfc00000, 0, 32'h0,        32'h0,        0); // 1 WAIT
    add(0, 0, 32'hbfc00004, 0, 0, 32'h0,        0, 32'hbfc00000, 1, 32'hbfc00000, 32'h24010001, 0); // 2 HOLD consume
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00004, 0, 32'hbfc00000, 32'h24010001, 0); // 3 REQ
    add(0, 0, 32'h0,        0, 1, 32'h24020002, 0, 32'hbfc00004, 0, 32'hbfc00000, 32'h24010001, 0); // 4 WAIT
    // Stall 5 cycles in HOLD; pc_selected must be ignored
    add(0, 1, 32'hbfc00008, 0, 0, 32'h0,        0, 32'hbfc00004, 1, 32'hbfc00004, 32'h24020002, 0); // 5
    add(0, 1, 32'h12345678, 1, 0, 32'h0,        0, 32'hbfc00004, 1, 32'hbfc00004, 32'h24020002, 0); // 6
    add(0, 1, 32'hbfc00008, 0, 1, 32'h0,        0, 32'hbfc00004, 1, 32'hbfc00004, 32'h24020002, 0); // 7
    add(0, 1, 32'hbfc00008, 0, 0, 32'h0,        0, 32'hbfc00004, 1, 32'hbfc00004, 32'h24020002, 0); // 8
    add(0, 1, 32'hbfc00008, 0, 0, 32'h0,        0, 32'hbfc00004, 1, 32'hbfc00004, 32'h24020002, 0); // 9
    add(0, 0, 32'hbfc00008, 0, 0, 32'h0,        0, 32'hbfc00004, 1, 32'hbfc00004, 32'h24020002, 0); // 10 release
    // Address not accepted for one cycle
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'hbfc00008, 0, 32'hbfc00004, 32'h24020002, 0); // 11
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'hbfc00008, 0, 32'hbfc00004, 32'h24020002, 0); // 12
    // Redirect in WAIT, data two cycles later is discarded
    add(1, 0, 32'h80000100, 0, 0, 32'h0,        0, 32'hbfc00008, 0, 32'hbfc00004, 32'h24020002, 0); // 13
    add(0, 0, 32'h0,        0, 0, 32'h0,        0, 32'h80000100, 0, 32'hbfc00004, 32'h24020002, 0); // 14
    add(0, 0, 32'h0,        0, 1, 32'hdeadbeef, 0, 32'h80000100, 0, 32'hbfc00004, 32'h24020002, 0); // 15
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h80000100, 0, 32'hbfc00004, 32'h24020002, 0); // 16
    // Redirect in the same cycle as idata_ok
    add(1, 0, 32'h80000200, 0, 1, 32'h11111111, 0, 32'h80000100, 0, 32'hbfc00004, 32'h24020002, 0); // 17
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h80000200, 0, 32'hbfc00004, 32'h24020002, 0); // 18
    add(0, 0, 32'h0,        0, 1, 32'h24030003, 0, 32'h80000200, 0, 32'hbfc00004, 32'h24020002, 0); // 19
    // Redirect + consume in HOLD: redirect wins, to a misaligned PC
    add(1, 0, 32'h80000102, 0, 0, 32'h0,        0, 32'h80000200, 1, 32'h80000200, 32'h24030003, 0); // 20
    add(0, 0, 32'h0,        1, 0, 32'h0,        0, 32'h80000102, 0, 32'h80000200, 32'h24030003, 0); // 21
    add(0, 1, 32'h0,        1, 0, 32'h0,        0, 32'h80000102, 1, 32'h80000102, 32'h0,        1); // 22
    add(0, 0, 32'h80000300, 0, 0, 32'h0,        0, 32'h80000102, 1, 32'h80000102, 32'h0,        1); // 23
    // Redirect in REQ suppresses the request
    add(1, 0, 32'h80000400, 1, 0, 32'h0,        0, 32'h80000300, 0, 32'h80000102, 32'h0,        1); // 24
    add(0, 0, 32'h0,        1, 0, 32'h0,        1, 32'h80000400, 0, 32'h80000102, 32'h0,        0); // 25
    // Back-to-back redirects while a response is outstanding
    add(1, 0, 32'h80000500, 0, 0, 32'h0,        0, 32'h80000400, 0, 32'h80000102, 32'h0,        0); // 26
    add(1, 0, 32'h80000600, 0, 0, 32'h0,        0, 32'h80000500, 0, 32'h80000102, 32'h0,        0); // 27
    add(0, 0, 32'h0,        0, 1, 32'haaaaaaaa, 0, 32'h80000600, 0, 32'h80000102, 32'h0,        0); // 28
    add(0, 0, 32'h0,        0, 0, 32'h0,        1, 32'h80000600, 0, 32'h80000102, 32'h0,        0); // 29

    drive(0, 0, 32'h0, 0, 0, 32'h0);
    resetn = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    resetn = 1'b1;
    check_all(100, 1, 32'hbfc00000, 0, 32'h0, 32'h0, 0);

    for (int i = 0; i < nv; i++) begin
      @(posedge clk);
      #1;
      drive(vecs[i].redirect, vecs[i].stall, vecs[i].pc_sel,
            vecs[i].aok, vecs[i].dok, vecs[i].idata);
      @(negedge clk);
      check_all(i, vecs[i].e_ireq, vecs[i].e_iaddr, vecs[i].e_fv,
                vecs[i].e_fpc, vecs[i].e_fi, vecs[i].e_adel);
    end

    // Fresh fetch into WAIT, then asynchronous reset mid-transaction
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 1, 0, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    chk("wait_ireq", 200, {31'd0, ireq}, 32'd0);
    #2;
    resetn = 1'b0;
    #1;
    chk("rst_async_iaddr", 201, iaddr, 32'hbfc00000);
    @(negedge clk);
    resetn = 1'b1;
    drive(0, 0, 32'h0, 0, 1, 32'h99999999);
    check_all(202, 1, 32'hbfc00000, 0, 32'h0, 32'h0, 0);
    // A response pending at reset arrives in REQ and must not fill the slot
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    check_all(203, 1, 32'hbfc00000, 0, 32'h0, 32'h0, 0);

    // pc_succ wraps modulo 2^32
    @(posedge clk); #1;
    drive(1, 0, 32'hfffffffc, 0, 0, 32'h0);
    @(posedge clk); #1;
    drive(0, 0, 32'h0, 0, 0, 32'h0);
    @(negedge clk);
    chk("wrap_pc_succ", 300, pc_succ, 32'h0);
    chk("wrap_ireq", 301, {31'd0, ireq}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
